// File: rtl/exception_monitor_pkg.sv
// Shared types and encodings for the runtime exception monitor.
package exception_pkg;

  typedef enum logic [1:0] {
    EXC_NONE       = 2'b00,
    EXC_DIV_ZERO   = 2'b01,
    EXC_PC_OVERRUN = 2'b10
  } exc_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_REPORT = 2'b10
  } mon_state_t;

  // Load-word opcode field and the RIM source register field.
  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] RIM_REG = 3'b111;

  // ProgState encodings.
  localparam logic [1:0] PS_IDLE  = 2'b00;
  localparam logic [1:0] PS_PROG1 = 2'b01;
  localparam logic [1:0] PS_PROG2 = 2'b10;
  localparam logic [1:0] PS_PROG3 = 2'b11;

endpackage

// File: rtl/exception_monitor_if.sv
// Exception report bus between the monitor (master) and the host (slave).
interface exception_monitor_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 4
);
  logic             ExcValid;
  logic [1:0]       ExcCode;
  logic [PC_W-1:0]  ExcPC;
  logic [CNT_W-1:0] ExcCount;
  logic             ExcLost;
  logic             ExcAck;

  modport master (
    output ExcValid, ExcCode, ExcPC, ExcCount, ExcLost,
    input  ExcAck
  );

  modport slave (
    input  ExcValid, ExcCode, ExcPC, ExcCount, ExcLost,
    output ExcAck
  );
endinterface

// File: rtl/exception_monitor_operand_capture.sv
// Decodes `lw Rk, RIM` and captures DataIn into operand k; flags all-zero operands.
module operand_capture
  import exception_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int INSTR_W      = 9,
  parameter int NUM_OPERANDS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           en,
  input  logic [INSTR_W-1:0]             instruction,
  input  logic [DATA_W-1:0]              data_in,
  output logic [NUM_OPERANDS*DATA_W-1:0] operands,
  output logic                           all_zero
);

  logic [DATA_W-1:0] opnd_p1 [NUM_OPERANDS];
  logic [2:0]        reg_k_p0;
  logic              hit_p0;

  assign reg_k_p0 = instruction[5:3];
  assign hit_p0   = en && (instruction[8:6] == OP_LW) && (instruction[2:0] == RIM_REG)
                    && (int'(reg_k_p0) < NUM_OPERANDS);

  // Operand register file: cleared while idle, otherwise only the addressed byte loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPERANDS; i++) opnd_p1[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_OPERANDS; i++) opnd_p1[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OPERANDS; i++)
        if (hit_p0 && (int'(reg_k_p0) == i)) opnd_p1[i] <= data_in;
    end
  end

  // Pack operand 0 into the top slice so it reads as the most significant byte.
  always_comb begin
    operands = '0;
    for (int i = 0; i < NUM_OPERANDS; i++)
      operands[(NUM_OPERANDS-1-i)*DATA_W +: DATA_W] = opnd_p1[i];
  end

  assign all_zero = (operands == '0);

endmodule

// File: rtl/exception_monitor.sv
// Runtime exception monitor: divide-by-zero check at a checkpoint PC, PC runaway
// detection, and a valid/ack report channel with saturating count and lost flag.
module exception_monitor
  import exception_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int              INSTR_W      = 9,
  parameter int              PC_W         = 10,
  parameter int              NUM_OPERANDS = 2,
  parameter logic [PC_W-1:0] CHECK_PC     = 10'b00001_00100,
  parameter logic [PC_W-1:0] PC_LIMIT     = 10'h3FF,
  parameter logic [3:0]      STATE_MASK   = 4'b0010,
  parameter int              CNT_W        = 4
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [1:0]                     ProgState,
  input  logic [DATA_W-1:0]              DataIn,
  input  logic [INSTR_W-1:0]             Instruction,
  input  logic [PC_W-1:0]                PC,
  output logic [NUM_OPERANDS*DATA_W-1:0] Operands,
  exception_monitor_if.master            exc
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic en_p0, clear_p0, all_zero_p0, dz_p0, ov_p0, det_p0;

  mon_state_t       state_p1, state_nxt;
  logic             valid_p1, valid_nxt;
  exc_code_t        code_p1, code_nxt;
  logic [PC_W-1:0]  pc_p1, pc_nxt;
  logic [CNT_W-1:0] cnt_p1, cnt_nxt;
  logic             lost_p1, lost_nxt;

  assign clear_p0 = (ProgState == PS_IDLE);
  assign en_p0    = !clear_p0 && STATE_MASK[ProgState];

  operand_capture #(
    .DATA_W       (DATA_W),
    .INSTR_W      (INSTR_W),
    .NUM_OPERANDS (NUM_OPERANDS)
  ) u_capture (
    .clk         (CLK),
    .rst_n       (RST_N),
    .clear       (clear_p0),
    .en          (en_p0),
    .instruction (Instruction),
    .data_in     (DataIn),
    .operands    (Operands),
    .all_zero    (all_zero_p0)
  );

  // The zero check sees pre-edge operands, so a same-cycle capture is not visible.
  assign dz_p0  = en_p0 && (PC == CHECK_PC) && all_zero_p0;
  assign ov_p0  = en_p0 && (PC >= PC_LIMIT);
  assign det_p0 = dz_p0 || ov_p0;

  // State and report registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_p1 <= ST_IDLE;
      valid_p1 <= 1'b0;
      code_p1  <= EXC_NONE;
      pc_p1    <= '0;
      cnt_p1   <= '0;
      lost_p1  <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      valid_p1 <= valid_nxt;
      code_p1  <= code_nxt;
      pc_p1    <= pc_nxt;
      cnt_p1   <= cnt_nxt;
      lost_p1  <= lost_nxt;
    end
  end

  // Next state: idle clears everything; a detection in IDLE (leaving reset of the
  // program) or RUN opens a report; REPORT holds until acknowledged.
  always_comb begin
    state_nxt = state_p1;
    valid_nxt = valid_p1;
    code_nxt  = code_p1;
    pc_nxt    = pc_p1;
    cnt_nxt   = cnt_p1;
    lost_nxt  = lost_p1;
    if (clear_p0) begin
      state_nxt = ST_IDLE;
      valid_nxt = 1'b0;
      code_nxt  = EXC_NONE;
      pc_nxt    = '0;
      cnt_nxt   = '0;
      lost_nxt  = 1'b0;
    end else begin
      if (det_p0)          cnt_nxt  = sat_inc(cnt_p1);
      if (dz_p0 && ov_p0)  lost_nxt = 1'b1;
      case (state_p1)
        ST_IDLE, ST_RUN: begin
          state_nxt = ST_RUN;
          if (det_p0) begin
            state_nxt = ST_REPORT;
            valid_nxt = 1'b1;
            code_nxt  = dz_p0 ? EXC_DIV_ZERO : EXC_PC_OVERRUN;
            pc_nxt    = PC;
          end
        end
        ST_REPORT: begin
          if (exc.ExcAck) begin
            if (det_p0) begin
              code_nxt = dz_p0 ? EXC_DIV_ZERO : EXC_PC_OVERRUN;
              pc_nxt   = PC;
            end else begin
              state_nxt = ST_RUN;
              valid_nxt = 1'b0;
              code_nxt  = EXC_NONE;
            end
          end else if (det_p0) begin
            lost_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
          code_nxt  = EXC_NONE;
        end
      endcase
    end
  end

  assign exc.ExcValid = valid_p1;
  assign exc.ExcCode  = code_p1;
  assign exc.ExcPC    = pc_p1;
  assign exc.ExcCount = cnt_p1;
  assign exc.ExcLost  = lost_p1;

endmodule

// File: tb/tb_exception_monitor.sv
// Bench for exception_monitor: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a rule-level model.
module tb_exception_monitor;

  localparam logic [3:0] MASK    = 4'b0010;
  localparam logic [9:0] CHK_PC  = 10'h024;
  localparam logic [9:0] LIMIT   = 10'h100;
  localparam logic [8:0] NOP     = 9'h100;
  localparam logic [8:0] LW_R0   = 9'b000_000_111;
  localparam logic [8:0] LW_R1   = 9'b000_001_111;
  localparam logic [8:0] LW_R2   = 9'b000_010_111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ps = 2'b00;
  logic [7:0]  data = 8'h00;
  logic [8:0]  instr = NOP;
  logic [9:0]  pc = 10'h000;
  logic [15:0] operands;

  int n_cmp = 0;
  int n_fail = 0;

  exception_monitor_if #(.PC_W(10), .CNT_W(4)) exc_bus ();

  exception_monitor #(
    .DATA_W(8), .INSTR_W(9), .PC_W(10), .NUM_OPERANDS(2),
    .CHECK_PC(CHK_PC), .PC_LIMIT(LIMIT), .STATE_MASK(MASK), .CNT_W(4)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .ProgState(ps), .DataIn(data),
    .Instruction(instr), .PC(pc), .Operands(operands), .exc(exc_bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the monitor's rules stated directly.
  logic [7:0] m_ops [2];
  logic       m_pend, m_lost;
  logic [1:0] m_code;
  logic [9:0] m_pc;
  int         m_count;

  wire m_en   = (ps != 2'b00) && MASK[ps];
  wire m_zero = (m_ops[0] == 8'h00) && (m_ops[1] == 8'h00);
  wire m_dz   = m_en && (pc == CHK_PC) && m_zero;
  wire m_ov   = m_en && (pc >= LIMIT);
  wire m_det  = m_dz || m_ov;
  wire m_cap  = m_en && (instr[8:6] == 3'b000) && (instr[2:0] == 3'b111) && (instr[5:3] < 3'd2);

  // Model update on each clock edge, cleared by reset or idle program state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || ps == 2'b00) begin
      m_ops[0] <= 8'h00; m_ops[1] <= 8'h00;
      m_pend <= 1'b0; m_lost <= 1'b0; m_code <= 2'b00; m_pc <= 10'h000; m_count <= 0;
    end else begin
      if (m_cap) m_ops[instr[3]] <= data;
      if (m_det) m_count <= (m_count == 15) ? 15 : m_count + 1;
      if ((m_dz && m_ov) || (m_det && m_pend && !exc_bus.ExcAck)) m_lost <= 1'b1;
      if (m_det && (!m_pend || exc_bus.ExcAck)) begin
        m_pend <= 1'b1;
        m_code <= m_dz ? 2'b01 : 2'b10;
        m_pc   <= pc;
      end else if (m_pend && exc_bus.ExcAck) begin
        m_pend <= 1'b0;
        m_code <= 2'b00;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_operands", 32'(operands), 32'({m_ops[0], m_ops[1]}));
    check("cmp_valid", 32'(exc_bus.ExcValid), 32'(m_pend));
    check("cmp_code", 32'(exc_bus.ExcCode), 32'(m_code));
    check("cmp_pc", 32'(exc_bus.ExcPC), 32'(m_pc));
    check("cmp_count", 32'(exc_bus.ExcCount), 32'(m_count));
    check("cmp_lost", 32'(exc_bus.ExcLost), 32'(m_lost));
  end

  task automatic check_report(input string name, input logic v, input logic [1:0] c,
                              input logic [9:0] p, input logic [3:0] n, input logic l);
    check({name, "_valid"}, 32'(exc_bus.ExcValid), 32'(v));
    check({name, "_code"},  32'(exc_bus.ExcCode),  32'(c));
    check({name, "_pc"},    32'(exc_bus.ExcPC),    32'(p));
    check({name, "_count"}, 32'(exc_bus.ExcCount), 32'(n));
    check({name, "_lost"},  32'(exc_bus.ExcLost),  32'(l));
  endtask

  initial begin
    exc_bus.ExcAck = 1'b0;

    // Reset state
    @(negedge clk);
    check_report("reset", 1'b0, 2'b00, 10'h000, 4'd0, 1'b0);
    check("reset_operands", 32'(operands), 32'h0);
    rst_n = 1'b1;

    // Divide by zero with two zero operands, held report, then ack
    ps = 2'b01; instr = LW_R0; data = 8'h00; pc = 10'h000;
    @(negedge clk); instr = LW_R1; data = 8'h00;
    @(negedge clk); instr = NOP; pc = CHK_PC;
    @(negedge clk);
    check_report("dz_first", 1'b1, 2'b01, 10'h024, 4'd1, 1'b0);
    pc = 10'h000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_report("dz_hold", 1'b1, 2'b01, 10'h024, 4'd1, 1'b0);
    end
    exc_bus.ExcAck = 1'b1;
    @(negedge clk);
    check("dz_ack_valid", 32'(exc_bus.ExcValid), 32'h0);
    check("dz_ack_code", 32'(exc_bus.ExcCode), 32'h0);
    exc_bus.ExcAck = 1'b0;

    // Non-zero divisor suppresses the check; out-of-range register is ignored
    instr = LW_R0; data = 8'h00;
    @(negedge clk); instr = LW_R1; data = 8'h05;
    @(negedge clk); instr = NOP; pc = CHK_PC;
    @(negedge clk);
    check("nz_valid", 32'(exc_bus.ExcValid), 32'h0);
    check("nz_operands", 32'(operands), 32'h0005);
    pc = 10'h000; instr = LW_R2; data = 8'hFF;
    @(negedge clk);
    check("r2_operands", 32'(operands), 32'h0005);
    check("r2_count", 32'(exc_bus.ExcCount), 32'd1);
    instr = NOP;

    // Masked program state: no capture, no exception
    ps = 2'b00;
    @(negedge clk); ps = 2'b10; instr = LW_R0; data = 8'h11;
    @(negedge clk); instr = NOP; pc = CHK_PC;
    @(negedge clk);
    check("mask_operands", 32'(operands), 32'h0);
    check_report("mask", 1'b0, 2'b00, 10'h000, 4'd0, 1'b0);
    pc = 10'h000;

    // Overrun while a divide-by-zero report is pending
    ps = 2'b01;
    @(negedge clk); pc = CHK_PC;
    @(negedge clk);
    check_report("lost_pre", 1'b1, 2'b01, 10'h024, 4'd1, 1'b0);
    pc = 10'h100;
    @(negedge clk);
    check_report("lost", 1'b1, 2'b01, 10'h024, 4'd2, 1'b1);
    pc = 10'h000; exc_bus.ExcAck = 1'b1;
    @(negedge clk);
    check("lost_ack_valid", 32'(exc_bus.ExcValid), 32'h0);
    exc_bus.ExcAck = 1'b0;

    // Counter saturation with ack held high
    ps = 2'b00;
    @(negedge clk); ps = 2'b01;
    @(negedge clk); pc = CHK_PC; exc_bus.ExcAck = 1'b1;
    repeat (20) @(negedge clk);
    check_report("sat", 1'b1, 2'b01, 10'h024, 4'd15, 1'b0);
    pc = 10'h000;
    @(negedge clk); exc_bus.ExcAck = 1'b0;

    // Program state drops to idle mid-report
    ps = 2'b00;
    @(negedge clk); ps = 2'b01;
    @(negedge clk); pc = CHK_PC;
    @(negedge clk);
    check("mid_valid", 32'(exc_bus.ExcValid), 32'h1);
    ps = 2'b00; pc = 10'h000;
    @(negedge clk);
    check_report("idle_clear", 1'b0, 2'b00, 10'h000, 4'd0, 1'b0);
    check("idle_operands", 32'(operands), 32'h0);

    // Asynchronous reset in the middle of a report
    ps = 2'b01;
    @(negedge clk); pc = CHK_PC;
    @(negedge clk);
    check("pre_rst_valid", 32'(exc_bus.ExcValid), 32'h1);
    pc = 10'h000;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_report("async_rst", 1'b0, 2'b00, 10'h000, 4'd0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      case ($urandom_range(31, 0))
        0:       ps = 2'b00;
        1, 2:    ps = 2'b10;
        3, 4:    ps = 2'b11;
        default: ps = 2'b01;
      endcase
      if ($urandom_range(9, 0) < 6) instr = {3'b000, 3'($urandom_range(3, 0)), 3'b111};
      else instr = 9'($urandom);
      data = ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom);
      case ($urandom_range(7, 0))
        0, 1, 2: pc = CHK_PC;
        3:       pc = 10'($urandom_range(32'h3FF, 32'h100));
        4:       pc = 10'h0FF;
        default: pc = 10'($urandom);
      endcase
      exc_bus.ExcAck = 1'($urandom_range(1, 0));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exception_monitor.md
Name: exception_monitor

Overview:
- Parametrised runtime exception monitor on the processor's fetch/writeback side.
- Snoops `lw Rk, RIM` instructions to capture up to NUM_OPERANDS data bytes (multi-byte divisor), checks them at a programmable checkpoint PC, and flags PC runaway.
- Reports exceptions to the testbench/host via a valid/ack handshake, with a saturating exception counter and a lost-event flag.

Parameters:
- DATA_W, 8: width of DataIn and of each captured operand byte.
- INSTR_W, 9: instruction width.
- PC_W, 10: program counter width.
- NUM_OPERANDS, 2: captured operand bytes, 1..8; register k (k < NUM_OPERANDS) maps to operand k, operand 0 = MSB.
- CHECK_PC, 10'b00001_00100: PC at which the divide-by-zero check fires.
- PC_LIMIT, 10'h3FF: PC >= PC_LIMIT in an enabled state raises PC_OVERRUN.
- STATE_MASK, 4'b0010: bit s set = monitoring enabled in ProgState s; bit 0 is ignored.
- CNT_W, 4: exception counter width.

Ports:
- CLK, input, 1: clock, rising edge.
- RST_N, input, 1: reset, asynchronous, active-low.
- ProgState, input, 2: 00 = idle/clear; 01/10/11 = program 1/2/3 running.
- DataIn, input, DATA_W: load data from the RIM path.
- Instruction, input, INSTR_W: current instruction.
- PC, input, PC_W: current PC.
- ExcAck, input, 1: host acknowledge.
- Operands, output, NUM_OPERANDS*DATA_W: captured bytes, operand 0 in the top slice.
- ExcValid, output, 1: exception report pending.
- ExcCode, output, 2: 00 none, 01 DIV_ZERO, 10 PC_OVERRUN, 11 reserved.
- ExcPC, output, PC_W: PC at which the reported exception was detected.
- ExcCount, output, CNT_W: saturating count of all detected exceptions.
- ExcLost, output, 1: sticky; a detection occurred while a report was already pending.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Operands = 0, ExcValid = 0, ExcCode = 00, ExcPC = 0, ExcCount = 0, ExcLost = 0.
  - FSM goes to IDLE.
- Enable: en = (ProgState != 00) && STATE_MASK[ProgState].
- Capture:
  - Condition: en, Instruction[8:6] == 000, Instruction[2:0] == 111, and k = Instruction[5:3] < NUM_OPERANDS.
  - Operand k <= DataIn at the next edge.
  - Other operands hold; loads with k >= NUM_OPERANDS are ignored.
- DIV_ZERO detect: en && PC == CHECK_PC && all registered operands == 0.
  - The check uses pre-edge register values, so a capture in the same cycle is not visible to it.
- PC_OVERRUN detect: en && PC >= PC_LIMIT, evaluated every cycle.
  - A PC that holds at or above PC_LIMIT re-detects each cycle; the counter and lost flag absorb the repeats.
- FSM states IDLE, RUN, REPORT:
  - IDLE: while ProgState == 00, synchronously clear Operands, ExcCount, ExcLost, ExcValid, ExcCode, ExcPC. Go to RUN when ProgState != 00.
  - RUN: a detection loads ExcCode/ExcPC and sets ExcValid at the next edge (latency 1 cycle), then go to REPORT.
  - REPORT: ExcValid, ExcCode and ExcPC are held stable until ExcAck is sampled high.
    - Ack with no new detection: ExcValid = 0 and ExcCode = 00 next cycle; return to RUN.
    - Ack together with a new detection: ExcValid stays 1 and the new code/PC load; stay in REPORT.
    - New detection without ack: the report is unchanged and ExcLost is set.
  - ExcAck outside REPORT is ignored.
- Counting:
  - ExcCount increments by 1 per cycle with at least one detection, and saturates at 2^CNT_W - 1.
  - Both codes detected in the same cycle: DIV_ZERO is reported, ExcCount += 1, and ExcLost is set.
- ProgState -> 00 from any state (including mid-report): go to IDLE and clear as in IDLE. A pending report is dropped without ack.
- ProgState changes between non-zero values: operands and counters are kept; en is re-evaluated against the new state.

Decomposition:
- Shared package `exception_pkg` holds:
  - exc_code_t enum (EXC_NONE, EXC_DIV_ZERO, EXC_PC_OVERRUN);
  - the monitor FSM state enum;
  - opcode constants for `lw`, RIM = 3'b111, and the ProgState encodings.
- One natural sub-module, `operand_capture`: instruction decode plus the operand register file, and it produces the all-zero flag.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- ProgState = 01; `lw R0, RIM` with DataIn = 0x00; `lw R1, RIM` with DataIn = 0x00; PC = 0x024 -> next cycle ExcValid = 1, ExcCode = 01, ExcPC = 0x024, ExcCount = 1. Hold ExcAck low 3 cycles -> outputs stable; ExcAck = 1 -> ExcValid = 0 next cycle.
- Load operands 0x00/0x05, then PC = 0x024 -> no exception, Operands = 0x0005. Then `lw R2, RIM` with DataIn = 0xFF -> ignored (NUM_OPERANDS = 2).
- ProgState = 10 with the default mask; zero operands, PC = 0x024 -> no capture, no exception, ExcCount = 0.
- PC_LIMIT = 0x100: PC = 0x100 while REPORT from DIV_ZERO is pending -> ExcLost = 1, ExcCount = 2, report still DIV_ZERO. Then ack -> ExcValid = 0.
- 20 repeated DIV_ZERO detections with ExcAck tied high -> ExcCount saturates at 15, ExcLost = 0.
- Mid-report: ProgState -> 00 -> next cycle all outputs = 0. RST_N pulsed low mid-cycle -> outputs clear immediately, without waiting for a CLK edge.
